// File: rtl/mips_pkg.sv
// Shared encodings for the pipelined MIPS integer core: opcode/funct values,
// instruction field positions and the internal ALU operation set.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam int OP_LSB  = 26;
    localparam int OP_W    = 6;
    localparam int RS_LSB  = 21;
    localparam int RT_LSB  = 16;
    localparam int RD_LSB  = 11;
    localparam int FN_LSB  = 0;
    localparam int FN_W    = 6;
    localparam int IMM_LSB = 0;
    localparam int IMM_W   = 16;

    // ALU_PASSB forwards operand B unchanged; LUI prepares its value in decode.
    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLT,
        ALU_PASSB
    } alu_op_e;

endpackage

// File: rtl/mips_pipe_regfile.sv
// Register file: two combinational reads, one synchronous write, r0 hard-wired
// to zero, and the same-cycle write value bypassed to the read ports.
module mips_pipe_regfile #(
    parameter int DATA_W  = 32,
    parameter int REG_NUM = 32
) (
    input  logic                       clk_i,
    input  logic                       we_i,
    input  logic [$clog2(REG_NUM)-1:0] waddr_i,
    input  logic [DATA_W-1:0]          wdata_i,
    input  logic [$clog2(REG_NUM)-1:0] raddr_a_i,
    input  logic [$clog2(REG_NUM)-1:0] raddr_b_i,
    output logic [DATA_W-1:0]          rdata_a_o,
    output logic [DATA_W-1:0]          rdata_b_o
);

    logic [DATA_W-1:0] mem_q [REG_NUM];

    always_ff @(posedge clk_i) begin
        if (we_i && waddr_i != '0) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = (raddr_a_i == '0)                   ? '0      :
                       (we_i && waddr_i == raddr_a_i)      ? wdata_i :
                                                             mem_q[raddr_a_i];
    assign rdata_b_o = (raddr_b_i == '0)                   ? '0      :
                       (we_i && waddr_i == raddr_b_i)      ? wdata_i :
                                                             mem_q[raddr_b_i];

endmodule

// File: rtl/mips_pipe_core.sv
// Four-stage (fetch, decode, execute, writeback) in-order MIPS integer core,
// ALU subset only, with full forwarding and fetch stalls on ROM not-ready.
module mips_pipe_core
    import mips_pkg::*;
#(
    parameter int              DATA_W   = 32,
    parameter int              REG_NUM  = 32,
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [31:0]                inst,
    input  logic                       romReady,
    output logic                       romCe,
    output logic [PC_W-1:0]            pc,
    output logic                       dbgWe,
    output logic [$clog2(REG_NUM)-1:0] dbgWAddr,
    output logic [DATA_W-1:0]          dbgWData
);

    localparam int AW = $clog2(REG_NUM);

    logic [PC_W-1:0]   pc_q, pc_d;
    logic              d_vld_q, d_vld_d;
    logic [31:0]       d_inst_q;
    logic              e_we_q, e_we_d;
    logic [AW-1:0]     e_waddr_q, e_waddr_d;
    alu_op_e           e_op_q, e_op_d;
    logic [DATA_W-1:0] e_a_q, e_a_d, e_b_q, e_b_d;
    logic              w_we_q;
    logic [AW-1:0]     w_waddr_q;
    logic [DATA_W-1:0] w_data_q;

    logic [OP_W-1:0]   op;
    logic [FN_W-1:0]   fn;
    logic [IMM_W-1:0]  imm;
    logic [AW-1:0]     rs, rt, rd;
    logic [DATA_W-1:0] rf_a, rf_b, rs_val, rt_val, alu_res;

    assign romCe    = ~rst;
    assign pc       = pc_q;
    assign dbgWe    = w_we_q;
    assign dbgWAddr = w_waddr_q;
    assign dbgWData = w_data_q;

    assign pc_d    = romReady ? pc_q + PC_W'(4) : pc_q;
    assign d_vld_d = romReady;

    assign op  = d_inst_q[OP_LSB +: OP_W];
    assign fn  = d_inst_q[FN_LSB +: FN_W];
    assign imm = d_inst_q[IMM_LSB +: IMM_W];
    assign rs  = d_inst_q[RS_LSB +: AW];
    assign rt  = d_inst_q[RT_LSB +: AW];
    assign rd  = d_inst_q[RD_LSB +: AW];

    // A write in flight at a reset edge belongs to a discarded instruction.
    mips_pipe_regfile #(
        .DATA_W  (DATA_W),
        .REG_NUM (REG_NUM)
    ) u_rf (
        .clk_i     (clk),
        .we_i      (w_we_q & ~rst),
        .waddr_i   (w_waddr_q),
        .wdata_i   (w_data_q),
        .raddr_a_i (rs),
        .raddr_b_i (rt),
        .rdata_a_o (rf_a),
        .rdata_b_o (rf_b)
    );

    // E-stage result takes priority; W and the array are resolved in the regfile.
    assign rs_val = (e_we_q && e_waddr_q == rs) ? alu_res : rf_a;
    assign rt_val = (e_we_q && e_waddr_q == rt) ? alu_res : rf_b;

    always_comb begin
        e_we_d    = 1'b0;
        e_waddr_d = rt;
        e_op_d    = ALU_ADD;
        e_a_d     = rs_val;
        e_b_d     = rt_val;
        case (op)
            OP_RTYPE: begin
                e_waddr_d = rd;
                e_we_d    = 1'b1;
                case (fn)
                    FN_ADD:  e_op_d = ALU_ADD;
                    FN_SUB:  e_op_d = ALU_SUB;
                    FN_AND:  e_op_d = ALU_AND;
                    FN_OR:   e_op_d = ALU_OR;
                    FN_XOR:  e_op_d = ALU_XOR;
                    FN_SLT:  e_op_d = ALU_SLT;
                    default: e_we_d = 1'b0;
                endcase
            end
            OP_ADDI: begin e_we_d = 1'b1; e_op_d = ALU_ADD; e_b_d = DATA_W'($signed(imm)); end
            OP_ANDI: begin e_we_d = 1'b1; e_op_d = ALU_AND; e_b_d = DATA_W'(imm); end
            OP_ORI:  begin e_we_d = 1'b1; e_op_d = ALU_OR;  e_b_d = DATA_W'(imm); end
            OP_XORI: begin e_we_d = 1'b1; e_op_d = ALU_XOR; e_b_d = DATA_W'(imm); end
            OP_LUI:  begin e_we_d = 1'b1; e_op_d = ALU_PASSB; e_b_d = DATA_W'({imm, 16'h0000}); end
            default: ;
        endcase
        if (!d_vld_q || e_waddr_d == '0) begin
            e_we_d = 1'b0;
        end
    end

    always_comb begin
        alu_res = '0;
        case (e_op_q)
            ALU_ADD:   alu_res = e_a_q + e_b_q;
            ALU_SUB:   alu_res = e_a_q - e_b_q;
            ALU_AND:   alu_res = e_a_q & e_b_q;
            ALU_OR:    alu_res = e_a_q | e_b_q;
            ALU_XOR:   alu_res = e_a_q ^ e_b_q;
            ALU_SLT:   alu_res = DATA_W'($signed(e_a_q) < $signed(e_b_q));
            ALU_PASSB: alu_res = e_b_q;
            default:   ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            d_vld_q   <= 1'b0;
            e_we_q    <= 1'b0;
            w_we_q    <= 1'b0;
            w_waddr_q <= '0;
            w_data_q  <= '0;
        end else begin
            pc_q      <= pc_d;
            d_vld_q   <= d_vld_d;
            e_we_q    <= e_we_d;
            w_we_q    <= e_we_q;
            w_waddr_q <= e_waddr_q;
            w_data_q  <= alu_res;
        end
    end

    // Datapath payload is qualified by the valid/write bits above.
    always_ff @(posedge clk) begin
        d_inst_q  <= inst;
        e_waddr_q <= e_waddr_d;
        e_op_q    <= e_op_d;
        e_a_q     <= e_a_d;
        e_b_q     <= e_b_d;
    end

endmodule

// File: tb/tb_mips_pipe_core.sv
// Scoreboard bench: stimulus pushes the expected writeback for each fetched
// instruction; a monitor pops and checks whenever the core reports a write.
module tb_mips_pipe_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        romReady = 1'b0;
    logic [31:0] inst = 32'h0;

    logic        romCe, romCe16, dbgWe, we16;
    logic [31:0] pc, pc16, dbgWData;
    logic [4:0]  dbgWAddr, wa16;
    logic [15:0] wd16;

    always #5 clk = ~clk;

    mips_pipe_core #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst), .inst(inst), .romReady(romReady), .romCe(romCe),
        .pc(pc), .dbgWe(dbgWe), .dbgWAddr(dbgWAddr), .dbgWData(dbgWData)
    );

    mips_pipe_core #(.DATA_W(16)) dut16 (
        .clk(clk), .rst(rst), .inst(inst), .romReady(romReady), .romCe(romCe16),
        .pc(pc16), .dbgWe(we16), .dbgWAddr(wa16), .dbgWData(wd16)
    );

    typedef struct {
        logic [31:0] ins;
        bit          we;
        logic [4:0]  wa;
        logic [31:0] d32;
        logic [15:0] d16;
    } ent_t;

    typedef struct {
        int          cyc;
        logic [4:0]  wa;
        logic [31:0] d32;
        logic [15:0] d16;
    } exp_t;

    ent_t        prog[$];
    exp_t        sb[$];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          fi = 0;
    logic [31:0] pcm = 32'h0;
    bit          done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ei(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] er(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    task automatic add(input logic [31:0] i, input bit w, input logic [4:0] a,
                       input logic [31:0] d, input logic [15:0] h);
        ent_t x;
        x.ins = i; x.we = w; x.wa = a; x.d32 = d; x.d16 = h;
        prog.push_back(x);
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One clock of stimulus: check fetch-side outputs, then drive the next edge.
    task automatic cycle(input bit r, input bit rdy);
        exp_t e;
        @(negedge clk); #1;
        check("pc", pc, pcm);
        check("pc16", pc16, pcm);
        check("romCe", romCe, !rst);
        check("romCe16", romCe16, !rst);
        rst      = r;
        inst     = 32'hFFFF_FFFF;
        romReady = 1'b0;
        if (r) begin
            romReady = rdy;
            pcm      = 32'h0;
        end else if (rdy && fi < prog.size()) begin
            romReady = 1'b1;
            inst     = prog[fi].ins;
            if (prog[fi].we) begin
                e.cyc = cyc + 3; e.wa = prog[fi].wa; e.d32 = prog[fi].d32; e.d16 = prog[fi].d16;
                sb.push_back(e);
            end
            fi++;
            pcm += 32'd4;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!done) begin
            if (sb.size() > 0 && sb[0].cyc < cyc) begin
                n_cmp++; n_bad++;
                $display("FAIL missing_write: r%0d never written, due cycle %0d", sb[0].wa, sb[0].cyc);
                void'(sb.pop_front());
            end
            if (dbgWe) begin
                if (sb.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_write: r%0d=%0h at cycle %0d, none required", dbgWAddr, dbgWData, cyc);
                end else begin
                    e = sb.pop_front();
                    check("w_cycle", cyc, e.cyc);
                    check("w_addr", dbgWAddr, e.wa);
                    check("w_data", dbgWData, e.d32);
                    check("w16_we", we16, 1'b1);
                    check("w16_addr", wa16, e.wa);
                    check("w16_data", wd16, e.d16);
                end
            end
        end
    end

    initial begin
        add(ei(6'h0D, 0, 1, 16'h00FF), 1, 1,  32'h0000_00FF, 16'h00FF); // ORI r1
        add(ei(6'h0D, 0, 1, 16'h0005), 1, 1,  32'h0000_0005, 16'h0005); // ORI r1,5
        add(ei(6'h08, 1, 2, 16'h0003), 1, 2,  32'h0000_0008, 16'h0008); // ADDI r2
        add(er(2, 1, 3, 6'h20),        1, 3,  32'h0000_000D, 16'h000D); // ADD r3
        add(ei(6'h08, 0, 4, 16'hFFFF), 1, 4,  32'hFFFF_FFFF, 16'hFFFF); // ADDI r4,-1
        add(ei(6'h0D, 0, 0, 16'h1234), 0, 0,  32'h0,         16'h0);    // ORI r0
        add(er(0, 0, 5, 6'h25),        1, 5,  32'h0000_0000, 16'h0000); // OR r5
        add(ei(6'h0F, 0, 6, 16'h8000), 1, 6,  32'h8000_0000, 16'h0000); // LUI r6
        add(er(6, 0, 7, 6'h2A),        1, 7,  32'h0000_0001, 16'h0000); // SLT r7
        add(er(0, 6, 8, 6'h22),        1, 8,  32'h8000_0000, 16'h0000); // SUB r8
        add(ei(6'h3F, 1, 2, 16'h1234), 0, 0,  32'h0,         16'h0);    // undefined op
        add(ei(6'h0C, 4, 9, 16'hF0F0), 1, 9,  32'h0000_F0F0, 16'hF0F0); // ANDI r9
        add(ei(6'h0E, 3, 10, 16'h000F),1, 10, 32'h0000_0002, 16'h0002); // XORI r10
        add(er(4, 3, 11, 6'h24),       1, 11, 32'h0000_000D, 16'h000D); // AND r11
        add(er(1, 2, 12, 6'h26),       1, 12, 32'h0000_000D, 16'h000D); // XOR r12
        add(er(0, 6, 13, 6'h2A),       1, 13, 32'h0000_0000, 16'h0000); // SLT r13
        add(er(1, 2, 14, 6'h22),       1, 14, 32'hFFFF_FFFD, 16'hFFFD); // SUB r14
        add(er(1, 2, 15, 6'h21),       0, 0,  32'h0,         16'h0);    // funct 0x21
        add(er(8, 6, 15, 6'h20),       1, 15, 32'h0000_0000, 16'h0000); // ADD wraps
        add(ei(6'h0D, 0, 20, 16'h0001),1, 20, 32'h0000_0001, 16'h0001); // reaches W
        add(ei(6'h0D, 0, 21, 16'h0002),0, 0,  32'h0,         16'h0);    // flushed
        add(ei(6'h0D, 0, 22, 16'h0003),0, 0,  32'h0,         16'h0);    // flushed
        add(er(3, 0, 16, 6'h20),       1, 16, 32'h0000_000D, 16'h000D); // ADD r16
        add(ei(6'h0D, 0, 17, 16'h0007),1, 17, 32'h0000_0007, 16'h0007); // ORI r17
        add(er(17, 16, 18, 6'h20),     1, 18, 32'h0000_0014, 16'h0014); // ADD r18

        repeat (3) @(negedge clk);
        #1;
        check("rst_we", dbgWe, 1'b0);
        check("rst_waddr", dbgWAddr, 5'd0);
        check("rst_wdata", dbgWData, 32'h0);
        check("rst_wdata16", wd16, 16'h0);

        cycle(0, 1);
        cycle(0, 0);
        cycle(0, 0);
        repeat (7) cycle(0, 1);
        cycle(0, 0);
        while (fi < 19) cycle(0, 1);
        repeat (4) cycle(0, 0);

        repeat (3) cycle(0, 1);
        cycle(1, 1);
        @(negedge clk); #1;
        check("midrst_we", dbgWe, 1'b0);
        check("midrst_we16", we16, 1'b0);
        check("midrst_pc", pc, 32'h0);

        while (fi < prog.size()) cycle(0, 1);
        repeat (5) cycle(0, 0);

        done = 1'b1;
        check("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
